// File: rtl/instr_cache_refill_ctrl_pkg.sv
// Shared types and beat-geometry helpers for the instruction cache refill path.
package instr_cache_pkg;

    localparam int unsigned BeatWidth = 64;
    localparam int unsigned BeatBytes = BeatWidth / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        COLLECT = 2'd2,
        WRITE   = 2'd3
    } refill_state_t;

    function automatic int unsigned beatsPerLine(input int unsigned blockBytes);
        return blockBytes / BeatBytes;
    endfunction

    function automatic int unsigned beatIdxWidth(input int unsigned blockBytes);
        return $clog2(blockBytes / BeatBytes);
    endfunction

endpackage

// File: rtl/instr_cache_refill_ctrl_if.sv
// L2 request/response channel between the refill controller and the L2 interface.
interface instr_cache_refill_ctrl_if
    import instr_cache_pkg::*;
#(
    parameter int unsigned AddrWidth = 32
) ();

    logic                 L2Req;
    logic [AddrWidth-1:0] L2Addr;
    logic                 L2Ready;
    logic                 L2Valid;
    logic [BeatWidth-1:0] L2Data;

    modport master (
        output L2Req,
        output L2Addr,
        input  L2Ready,
        input  L2Valid,
        input  L2Data
    );

    modport slave (
        input  L2Req,
        input  L2Addr,
        output L2Ready,
        output L2Valid,
        output L2Data
    );

endinterface

// File: rtl/instr_cache_refill_ctrl_line_buf.sv
// Line buffer: one synchronous write port fed by L2 beats, one asynchronous read port
// that feeds the cache set during the contiguous write burst.
module instr_refill_line_buf
    import instr_cache_pkg::*;
#(
    parameter int unsigned Depth    = 8,
    parameter int unsigned IdxWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IdxWidth-1:0]  wrIdx,
    input  logic [BeatWidth-1:0] wrData,
    input  logic [IdxWidth-1:0]  rdIdx,
    output logic [BeatWidth-1:0] rdData
);

    logic [BeatWidth-1:0] mem [Depth];

    always_ff @(posedge clk) begin : writePort
        if (we) begin
            mem[wrIdx] <= wrData;
        end
    end

    assign rdData = mem[rdIdx];

endmodule

// File: rtl/instr_cache_refill_ctrl.sv
// Instruction cache miss handler: fetches a block from L2 into a gap-tolerant line
// buffer, then streams it into the cache set as one unbroken run of RepEnable cycles.
module instr_cache_refill_ctrl
    import instr_cache_pkg::*;
#(
    parameter int unsigned B         = 64,
    parameter int unsigned AddrWidth = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [AddrWidth-1:0]      PCF,
    input  logic                      CacheMiss,
    input  logic                      Redirect,
    instr_cache_refill_ctrl_if.master l2,
    output logic                      RepEnable,
    output logic [BeatWidth-1:0]      RepWord,
    output logic                      RefillAddrSel,
    output logic [AddrWidth-1:0]      RefillAddr,
    output logic                      StallF
);

    localparam int unsigned NB   = beatsPerLine(B);
    localparam int unsigned CntW = beatIdxWidth(B);
    localparam logic [AddrWidth-1:0] OffsetMask = AddrWidth'(B - 1);
    localparam logic [CntW-1:0]      LastIdx    = CntW'(NB - 1);

    refill_state_t        state;
    refill_state_t        stateNext;
    logic [AddrWidth-1:0] missAddr;
    logic                 abortFlag;
    logic [CntW-1:0]      beatCnt;
    logic [CntW-1:0]      wrCnt;
    logic                 l2ReqQ;
    logic                 repEnableQ;
    logic [BeatWidth-1:0] repWordQ;

    logic                 missAccept;
    logic                 l2ReqNext;
    logic                 repEnableNext;
    logic                 bufWe;
    logic [CntW-1:0]      rdIdx;
    logic [BeatWidth-1:0] bufRdData;

    // Redirect wins over a miss in the same cycle: the miss belongs to the wrong path.
    assign missAccept = (state == IDLE) && CacheMiss && !Redirect;

    always_ff @(posedge clk) begin : stateReg
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin : nextState
        stateNext = state;
        case (state)
            IDLE:    if (missAccept) stateNext = REQ;
            REQ:     if (l2.L2Ready) stateNext = COLLECT;
            COLLECT: if (l2.L2Valid && (beatCnt == LastIdx)) begin
                         stateNext = abortFlag ? IDLE : WRITE;
                     end
            WRITE:   if (wrCnt == LastIdx) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered; the word for the next
    // write cycle is prefetched from the buffer one cycle ahead.
    always_comb begin : outputDecode
        l2ReqNext     = 1'b0;
        repEnableNext = 1'b0;
        bufWe         = 1'b0;
        rdIdx         = wrCnt;
        l2ReqNext     = (stateNext == REQ);
        repEnableNext = (stateNext == WRITE);
        bufWe         = (state == COLLECT) && l2.L2Valid;
        if (state == WRITE) begin
            rdIdx = wrCnt + CntW'(1);
        end
    end

    // Abort only discards the line; the L2 burst is always drained to its last beat.
    always_ff @(posedge clk) begin : datapathRegs
        if (reset) begin
            missAddr   <= '0;
            abortFlag  <= 1'b0;
            beatCnt    <= '0;
            wrCnt      <= '0;
            l2ReqQ     <= 1'b0;
            repEnableQ <= 1'b0;
            repWordQ   <= '0;
        end else begin
            l2ReqQ     <= l2ReqNext;
            repEnableQ <= repEnableNext;
            if (repEnableNext) begin
                repWordQ <= bufRdData;
            end
            if (missAccept) begin
                missAddr  <= PCF & ~OffsetMask;
                abortFlag <= 1'b0;
            end else if (Redirect && ((state == REQ) || (state == COLLECT))) begin
                abortFlag <= 1'b1;
            end
            if (bufWe) begin
                beatCnt <= beatCnt + CntW'(1);
            end
            if (state == WRITE) begin
                wrCnt <= wrCnt + CntW'(1);
            end
        end
    end

    instr_refill_line_buf #(
        .Depth    (NB),
        .IdxWidth (CntW)
    ) lineBuf (
        .clk    (clk),
        .we     (bufWe),
        .wrIdx  (beatCnt),
        .wrData (l2.L2Data),
        .rdIdx  (rdIdx),
        .rdData (bufRdData)
    );

    assign l2.L2Req      = l2ReqQ;
    assign l2.L2Addr     = missAddr;
    assign RepEnable     = repEnableQ;
    assign RefillAddrSel = repEnableQ;
    assign RepWord       = repWordQ;
    assign RefillAddr    = missAddr;
    assign StallF        = (state != IDLE) || (CacheMiss && !Redirect);

endmodule

// File: doc/instr_cache_refill_ctrl.md
# instr_cache_refill_ctrl

Miss-handling controller for the multi-cycle instruction cache. It sits between the cache set array and the L2 interface. On a fetch miss it requests the block from L2 and collects the 64-bit beats into a line buffer, which tolerates gaps between beats. It then streams the complete line into the cache set as one contiguous run of `RepEnable` cycles, as the set's refill counter requires, while stalling fetch.

## Interface
- `B`, 64, block size in bytes; power of two, ≥16; beats per line `NB = B/8`
- `AddrWidth`, 32, fetch address width
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `PCF`  in  AddrWidth  current fetch address
- `CacheMiss`  in  1  combined miss from the active set, valid in IDLE
- `Redirect`  in  1  branch/jump redirect of fetch (wrong-path kill)
- `L2Req`  out  1  request valid
- `L2Addr`  out  AddrWidth  block-aligned request address
- `L2Ready`  in  1  L2 accepts the request this cycle
- `L2Valid`  in  1  data beat valid
- `L2Data`  in  64  data beat; beat k carries bytes 8k..8k+7 of the block
- `RepEnable`  out  1  cache set write strobe
- `RepWord`  out  64  beat written to the set
- `RefillAddrSel`  out  1  cache index/tag must be taken from `RefillAddr`, not `PCF`
- `RefillAddr`  out  AddrWidth  latched miss address (block-aligned)
- `StallF`  out  1  hold PC/fetch stage

## Operation
- States: IDLE, REQ, COLLECT, WRITE.
- **IDLE**
  - `CacheMiss && !Redirect`: latch `MissAddr = {PCF[AddrWidth-1:log2B], 0}`, clear the abort flag, go to REQ.
  - `Redirect` has priority: the miss is dropped and the state stays IDLE.
- **REQ**
  - `L2Req=1`, `L2Addr=MissAddr`.
  - The request is held stable until `L2Ready`; it is never withdrawn.
  - On `L2Ready`: go to COLLECT with `BeatCnt=0`.
- **COLLECT**
  - Each cycle with `L2Valid`: `LineBuf[BeatCnt] <= L2Data`, then `BeatCnt++`. `L2Valid` outside COLLECT is ignored.
  - After beat NB-1 is accepted: go to WRITE if the abort flag is clear, else to IDLE (line discarded).
- **Abort flag**
  - Set by `Redirect` during REQ or COLLECT.
  - The outstanding L2 transaction is always drained to its last beat.
- **WRITE**
  - Lasts exactly NB consecutive cycles.
  - `RepEnable=1`, `RepWord=LineBuf[WrCnt]`, `RefillAddrSel=1`, `WrCnt` counts 0..NB-1.
  - After the last cycle: go to IDLE.
  - `Redirect` during WRITE is ignored by the controller. The fetch stage keeps the redirect pending because `StallF` is high.
- **StallF**: `(state != IDLE) || (CacheMiss && !Redirect)`.
- `RefillAddr = MissAddr` at all times. It is meaningful only while `RefillAddrSel=1`.
- Counters are log2(NB) bits and wrap to 0 naturally after NB-1; there is no separate clear.

## Timing
- **Reset values:**
  - State IDLE; `L2Req`, `RepEnable`, `RefillAddrSel` = 0.
  - `L2Addr`, `RefillAddr`, `RepWord` = 0; counters and abort flag = 0.
  - `StallF` follows its combinational equation, so it is 0 unless `CacheMiss` is high.
- Reset mid-refill returns to IDLE the next cycle with no write to the set. L2 is reset by the same `reset`.
- **Latency**, with the miss in cycle 0, `L2Ready` in cycle 1, and beats in cycles 2..NB+1 with no gaps:
  - WRITE occupies cycles NB+2..2NB+1.
  - The hit and `StallF=0` occur in cycle 2NB+2; for B=64 that is cycle 18.
- Each gap cycle in `L2Valid` adds one cycle. WRITE is never gapped.
- `RepWord` and `RepEnable` are registered (or come from a registered state plus an asynchronous buffer read). They are valid for the whole cycle.
- `L2Ready` and `L2Valid` in the same cycle while in REQ: only the request is accepted. The first beat must arrive no earlier than the cycle after `L2Ready`.

## Structure
- Package `instr_cache_pkg`: `refill_state_t` enum (IDLE, REQ, COLLECT, WRITE) and the `NB`/beat-width localparam helpers.
- Sub-module `instr_refill_line_buf`:
  - NB×64 distributed RAM.
  - One synchronous write port (COLLECT) and one asynchronous read port (WRITE).
- The FSM, counters and abort flag live in the top module.

## Test plan
- Cold miss, B=64, PCF=0x0000_1234, L2Ready immediate, 8 gapless beats D0..D7 → `L2Addr=0x1200`; RepEnable high in cycles 10..17 with RepWord D0..D7 in order; StallF low in cycle 18.
- Same miss with `L2Valid` gaps (beats in cycles 2,4,5,9,...) → WRITE still 8 contiguous cycles with RepWord D0..D7; start delayed by the gap count.
- Redirect in COLLECT after beat 3 → all 8 beats still consumed; no RepEnable pulse; state IDLE the cycle after beat 7.
- `Redirect` and `CacheMiss` in the same IDLE cycle → `L2Req` never asserts and `StallF` stays 0.
- `L2Ready` held low for 5 cycles → `L2Req`/`L2Addr` stable for all 6 cycles; no spurious `L2Valid` capture.
- Reset asserted in WRITE cycle 3 → next cycle `RepEnable=0`, `RefillAddrSel=0`, `L2Req=0`, and the FSM is in IDLE.
